mod_power_accumulator: RTL
==========================

// Module: mod_power_accumulator
// PURPOSE
//   Downstream consumer of the exponent stage in the Pollard p-1 datapath.
//   For each (prime q, exponent e) pair it updates acc <= acc^(q^e) mod N.
//   Each of the e rounds does acc <= acc^q mod N by left-to-right square-and-multiply.
//   acc is later handed to the gcd stage.
// PARAMETERS
//   WIDTH   16  bit width of modulus, accumulator and result
//   QBITS    9  bit width of prime q, matching the base bus of the exponent stage
//   EBITS    8  bit width of exponent e
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   modulus     in   WIDTH  N; held stable while busy; N >= 2 required
//   init        in   1      idle-only: acc <= init_value
//   init_value  in   WIDTH  seed value (normally 2); must be < N
//   start       in   1      idle-only: begin job with prime/exponent
//   prime       in   QBITS  q, sampled on accepted start
//   exponent    in   EBITS  e, sampled on accepted start
//   busy        out  1      high from accepted start until done
//   done        out  1      one-cycle pulse when acc holds the new value
//   acc         out  WIDTH  current accumulator
// BEHAVIOUR
//   Reset values: busy=0, done=0, acc=1, FSM=IDLE, all counters 0.
//   Reset mid-job: abort at once. No done pulse. Next job needs a fresh init.
//   Handshake rules:
//     - start and init are honoured only in IDLE; ignored while busy.
//     - init and start in the same cycle: init wins, start is dropped.
//     - prime and exponent are latched when start is accepted; busy rises the next cycle.
//   FSM states:
//     - IDLE --start--> ROUND.
//     - ROUND: if rounds_left==0, go to FIN. Otherwise base<=acc, res<=1, bit index<=msb(q), go to SQR.
//     - SQR: res<=res*res mod N (sub-module), then go to MUL.
//     - MUL: if q[bit]==1, res<=res*base mod N. Then go to NXT.
//     - NXT: if bit>0, bit--, go to SQR. Otherwise acc<=res, rounds_left--, go to ROUND.
//     - FIN: done=1 for one cycle, busy=0, return to IDLE.
//   Bits of q above its MSB are not processed. msb is found by a priority encoder when start is accepted.
//   Boundary cases:
//     - e==0: acc unchanged; done pulses exactly 2 cycles after start is accepted.
//     - q==0: result is 1 (empty product).
//     - q==1: acc unchanged after each round.
//   Modular multiply (Blakley shift-add), one multiplier bit per cycle, MSB first:
//     r <= 2r; if r>=N then r-=N; if b[i] then r+=a, and if r>=N then r-=N.
//     Intermediates are WIDTH+1 bits; operands must be < N.
//     Latency is exactly WIDTH cycles from mult start to mult done.
//   No overflow: all stored values stay < N < 2^WIDTH.
// STRUCTURE
//   Package pollard_pkg:
//     - state enum {IDLE, ROUND, SQR, MUL, NXT, FIN};
//     - default WIDTH/QBITS/EBITS constants, shared with the exponent stage and the gcd stage.
//   Sub-module mod_mult:
//     - ports clk, reset, start, a, b, n, done, p;
//     - this module instantiates one and time-shares it between SQR and MUL.
//   The top-level FSM, counters and priority encoder stay in this module.
// TESTING
//   1. N=1000, init 2, start q=2 e=3 -> done pulse, acc=256 (2^8).
//   2. Continue: start q=3 e=1 -> acc=216 (256^3 mod 1000).
//   3. N=13, init 2, start q=5 e=1 -> acc=6.
//      Also N=91, init 2, q=3 e=2 -> acc=57 (2^9 mod 91).
//   4. init 5, start e=0 (any q) -> done exactly 2 cycles after accept, acc=5.
//      Separately: q=0 e=1 -> acc=1.
//   5. Start pulses, a new init, and a start+init in the same IDLE cycle:
//      - during busy: all ignored; acc and done timing match the undisturbed job;
//      - in IDLE: init wins and no job starts.
//   6. Assert reset midway through the SQR of job 1:
//      - busy=0, acc=1 and done=0 in the same cycle;
//      - after release, init 2 then q=2 e=3 -> 256.

Source files
------------

// File: rtl/pollard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pollard_pkg
// Description : Shared widths and FSM state encodings for the Pollard p-1
//               datapath (exponent stage, power accumulator, gcd stage).
// Revision    : 1.0 - initial release
// ============================================================================
package pollard_pkg;

    // Default bus widths shared by every stage of the datapath
    localparam int POLLARD_WIDTH = 16;
    localparam int POLLARD_QBITS = 9;
    localparam int POLLARD_EBITS = 8;

    // Power-accumulator FSM state encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ROUND = 3'd1;
    localparam logic [2:0] SQR   = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] NXT   = 3'd4;
    localparam logic [2:0] FIN   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mod_mult.sv
`default_nettype none
// ============================================================================
// Module      : mod_mult
// Description : Blakley shift-add modular multiplier, p = a*b mod n.
//               One multiplier bit per cycle, MSB first. The first bit is
//               consumed on the start edge so done rises exactly WIDTH
//               cycles after the cycle in which start is high.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mult
    import pollard_pkg::*;
#(
    parameter int WIDTH = POLLARD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    logic             active;
    logic             done_q;

    // One Blakley step: double, reduce, conditionally add a, reduce.
    // Inputs are < n, so every intermediate fits in WIDTH+1 bits.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] r_in,
                                              input logic [WIDTH-1:0] a_in,
                                              input logic [WIDTH-1:0] n_in,
                                              input logic             bit_in);
        logic [WIDTH:0] t;
        t = {r_in, 1'b0};
        if (t >= {1'b0, n_in}) t = t - {1'b0, n_in};
        if (bit_in)            t = t + {1'b0, a_in};
        if (t >= {1'b0, n_in}) t = t - {1'b0, n_in};
        return t[WIDTH-1:0];
    endfunction

    // Latch operands on start and walk the multiplier bits MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            n_q    <= '0;
            b_sh   <= '0;
            r      <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active) begin
                r    <= step(r, a_q, n_q, b_sh[WIDTH-1]);
                b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                a_q    <= a;
                n_q    <= n;
                b_sh   <= {b[WIDTH-2:0], 1'b0};
                r      <= step('0, a, n, b[WIDTH-1]);
                cnt    <= CW'(WIDTH - 1);
                active <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign p    = r;

endmodule
`default_nettype wire

// File: rtl/mod_power_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mod_power_accumulator
// Description : For each (q, e) job computes acc <= acc^(q^e) mod N as e
//               rounds of acc <= acc^q mod N, each by left-to-right
//               square-and-multiply on a single time-shared mod_mult.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_power_accumulator
    import pollard_pkg::*;
#(
    parameter int WIDTH = POLLARD_WIDTH,
    parameter int QBITS = POLLARD_QBITS,
    parameter int EBITS = POLLARD_EBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] modulus,
    input  logic             init,
    input  logic [WIDTH-1:0] init_value,
    input  logic             start,
    input  logic [QBITS-1:0] prime,
    input  logic [EBITS-1:0] exponent,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc
);

    localparam int BW = $clog2(QBITS);

    state_t           state;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] res;
    logic [QBITS-1:0] q_reg;
    logic [BW-1:0]    msb_reg;
    logic [BW-1:0]    bit_idx;
    logic [EBITS-1:0] rounds_left;
    logic             pending;
    logic [BW-1:0]    msb;
    logic             q_bit;
    logic             mult_start;
    logic             mult_done;
    logic [WIDTH-1:0] mult_p;

    // Priority encoder: index of the highest set bit of prime (0 when prime==0)
    always_comb begin
        msb = '0;
        for (int i = 0; i < QBITS; i++) begin
            if (prime[i]) msb = BW'(i);
        end
    end

    assign q_bit      = q_reg[bit_idx];
    assign mult_start = ((state == SQR) || (state == MUL && q_bit)) && !pending;

    mod_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (mult_start),
        .a     (res),
        .b     ((state == SQR) ? res : base),
        .n     (modulus),
        .done  (mult_done),
        .p     (mult_p)
    );

    // Track an issued multiply so it is launched only once per SQR/MUL visit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           pending <= 1'b0;
        else if (mult_start) pending <= 1'b1;
        else if (mult_done)  pending <= 1'b0;
    end

    // Job sequencing: rounds of square-and-multiply over the bits of q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc_q       <= WIDTH'(1);
            base        <= '0;
            res         <= '0;
            q_reg       <= '0;
            msb_reg     <= '0;
            bit_idx     <= '0;
            rounds_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // init has priority; a simultaneous start is dropped
                    if (init) begin
                        acc_q <= init_value;
                    end else if (start) begin
                        q_reg       <= prime;
                        msb_reg     <= msb;
                        rounds_left <= exponent;
                        state       <= ROUND;
                    end
                end
                ROUND: begin
                    if (rounds_left == '0) begin
                        state <= FIN;
                    end else begin
                        base    <= acc_q;
                        res     <= WIDTH'(1);
                        bit_idx <= msb_reg;
                        state   <= SQR;
                    end
                end
                SQR: begin
                    if (mult_done) begin
                        res   <= mult_p;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (!q_bit) begin
                        state <= NXT;
                    end else if (mult_done) begin
                        res   <= mult_p;
                        state <= NXT;
                    end
                end
                NXT: begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        state   <= SQR;
                    end else begin
                        acc_q       <= res;
                        rounds_left <= rounds_left - 1'b1;
                        state       <= ROUND;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);
    assign acc  = acc_q;

endmodule
`default_nettype wire
